// File: rtl/sda_gmem_pkg.sv
// Shared definitions for the gmem responder: FSM encodings, AXI response codes
// and the byte-lane address shift.
package sda_gmem_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    function automatic int lsb_of(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/sda_gmem_ram.sv
// Byte-enabled word memory: one write port, one registered read port,
// read-before-write on a same-address collision.
module sda_gmem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [DEPTH_LOG2-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [DATA_WIDTH/8-1:0]   wr_strb,
    input  logic                      rd_en,
    input  logic                      rd_zero,
    input  logic [DEPTH_LOG2-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // The read register doubles as the AXI rdata output, so it is reset to 0
    // and can be forced to 0 for beats that fall outside the memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/sda_gmem_responder.sv
// AXI4 slave serving m_axi_gmem bursts from on-chip memory; independent read
// and write channels, one outstanding burst each, all bursts treated as INCR.
module sda_gmem_responder
    import sda_gmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_gmem_awaddr,
    input  logic [7:0]              s_axi_gmem_awlen,
    input  logic [2:0]              s_axi_gmem_awsize,
    input  logic [1:0]              s_axi_gmem_awburst,
    input  logic [3:0]              s_axi_gmem_awcache,
    input  logic                    s_axi_gmem_awvalid,
    output logic                    s_axi_gmem_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_gmem_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_gmem_wstrb,
    input  logic                    s_axi_gmem_wlast,
    input  logic                    s_axi_gmem_wvalid,
    output logic                    s_axi_gmem_wready,
    output logic [1:0]              s_axi_gmem_bresp,
    output logic                    s_axi_gmem_bvalid,
    input  logic                    s_axi_gmem_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_gmem_araddr,
    input  logic [7:0]              s_axi_gmem_arlen,
    input  logic [2:0]              s_axi_gmem_arsize,
    input  logic [1:0]              s_axi_gmem_arburst,
    input  logic [3:0]              s_axi_gmem_arcache,
    input  logic                    s_axi_gmem_arvalid,
    output logic                    s_axi_gmem_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_gmem_rdata,
    output logic [1:0]              s_axi_gmem_rresp,
    output logic                    s_axi_gmem_rlast,
    output logic                    s_axi_gmem_rvalid,
    input  logic                    s_axi_gmem_rready
);

    localparam int LSB    = lsb_of(DATA_WIDTH);
    localparam int IDX_HI = LSB + MEM_DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return |a[ADDR_WIDTH-1:IDX_HI];
    endfunction

    function automatic logic [MEM_DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_HI-1:LSB];
    endfunction

    wr_state_e             w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic                  w_err;

    rd_state_e             r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_oor, w_final, w_err_nxt;
    logic r_final, rd_en, rd_zero;
    logic [ADDR_WIDTH-1:0] r_addr_nxt, rd_addr_full;

    assign aw_hs = s_axi_gmem_awvalid & s_axi_gmem_awready;
    assign w_hs  = s_axi_gmem_wvalid  & s_axi_gmem_wready;
    assign b_hs  = s_axi_gmem_bvalid  & s_axi_gmem_bready;
    assign ar_hs = s_axi_gmem_arvalid & s_axi_gmem_arready;
    assign r_hs  = s_axi_gmem_rvalid  & s_axi_gmem_rready;

    // A beat is an error if it misses the memory or its wlast disagrees with the count.
    assign w_oor     = out_of_range(w_addr);
    assign w_final   = (w_cnt == w_len);
    assign w_err_nxt = w_err | w_oor | (s_axi_gmem_wlast != w_final);

    assign r_final      = (r_cnt == r_len);
    assign r_addr_nxt   = r_addr + BEAT_BYTES;
    assign rd_en        = ar_hs | (r_hs & ~r_final);
    assign rd_addr_full = ar_hs ? s_axi_gmem_araddr : r_addr_nxt;
    assign rd_zero      = out_of_range(rd_addr_full);

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_gmem_awsize, s_axi_gmem_awburst, s_axi_gmem_awcache,
                             s_axi_gmem_arsize, s_axi_gmem_arburst, s_axi_gmem_arcache};

    sda_gmem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (w_hs & ~w_oor),
        .wr_addr (word_idx(w_addr)),
        .wr_data (s_axi_gmem_wdata),
        .wr_strb (s_axi_gmem_wstrb),
        .rd_en   (rd_en),
        .rd_zero (rd_zero),
        .rd_addr (word_idx(rd_addr_full)),
        .rd_data (s_axi_gmem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state            <= W_IDLE;
            w_addr             <= '0;
            w_len              <= '0;
            w_cnt              <= '0;
            w_err              <= 1'b0;
            s_axi_gmem_awready <= 1'b0;
            s_axi_gmem_wready  <= 1'b0;
            s_axi_gmem_bvalid  <= 1'b0;
            s_axi_gmem_bresp   <= AXI_RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_addr             <= s_axi_gmem_awaddr;
                        w_len              <= s_axi_gmem_awlen;
                        w_cnt              <= '0;
                        w_err              <= 1'b0;
                        s_axi_gmem_awready <= 1'b0;
                        s_axi_gmem_wready  <= 1'b1;
                        w_state            <= W_DATA;
                    end else begin
                        s_axi_gmem_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_err <= w_err_nxt;
                        if (w_final) begin
                            s_axi_gmem_wready <= 1'b0;
                            s_axi_gmem_bvalid <= 1'b1;
                            s_axi_gmem_bresp  <= w_err_nxt ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                            w_state           <= W_RESP;
                        end else begin
                            w_cnt  <= w_cnt + 8'd1;
                            w_addr <= w_addr + BEAT_BYTES;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        s_axi_gmem_bvalid  <= 1'b0;
                        s_axi_gmem_bresp   <= AXI_RESP_OKAY;
                        s_axi_gmem_awready <= 1'b1;
                        w_state            <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // rdata comes from the RAM read register; this FSM keeps rresp/rlast aligned with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= R_IDLE;
            r_addr             <= '0;
            r_len              <= '0;
            r_cnt              <= '0;
            s_axi_gmem_arready <= 1'b0;
            s_axi_gmem_rvalid  <= 1'b0;
            s_axi_gmem_rlast   <= 1'b0;
            s_axi_gmem_rresp   <= AXI_RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_addr             <= s_axi_gmem_araddr;
                        r_len              <= s_axi_gmem_arlen;
                        r_cnt              <= '0;
                        s_axi_gmem_arready <= 1'b0;
                        s_axi_gmem_rvalid  <= 1'b1;
                        s_axi_gmem_rlast   <= (s_axi_gmem_arlen == 8'd0);
                        s_axi_gmem_rresp   <= rd_zero ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        r_state            <= R_DATA;
                    end else begin
                        s_axi_gmem_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (r_final) begin
                            s_axi_gmem_rvalid  <= 1'b0;
                            s_axi_gmem_rlast   <= 1'b0;
                            s_axi_gmem_rresp   <= AXI_RESP_OKAY;
                            s_axi_gmem_arready <= 1'b1;
                            r_state            <= R_IDLE;
                        end else begin
                            r_cnt            <= r_cnt + 8'd1;
                            r_addr           <= r_addr_nxt;
                            s_axi_gmem_rlast <= ((r_cnt + 8'd1) == r_len);
                            s_axi_gmem_rresp <= rd_zero ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sda_gmem_responder.sv
// Randomized bench for sda_gmem_responder against a word-array memory model.
module tb_sda_gmem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [3:0]  awcache;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    always #5 clk = ~clk;

    sda_gmem_responder dut (
        .clk(clk), .reset_n(reset_n),
        .s_axi_gmem_awaddr(awaddr), .s_axi_gmem_awlen(awlen), .s_axi_gmem_awsize(awsize),
        .s_axi_gmem_awburst(awburst), .s_axi_gmem_awcache(awcache),
        .s_axi_gmem_awvalid(awvalid), .s_axi_gmem_awready(awready),
        .s_axi_gmem_wdata(wdata), .s_axi_gmem_wstrb(wstrb), .s_axi_gmem_wlast(wlast),
        .s_axi_gmem_wvalid(wvalid), .s_axi_gmem_wready(wready),
        .s_axi_gmem_bresp(bresp), .s_axi_gmem_bvalid(bvalid), .s_axi_gmem_bready(bready),
        .s_axi_gmem_araddr(araddr), .s_axi_gmem_arlen(arlen), .s_axi_gmem_arsize(arsize),
        .s_axi_gmem_arburst(arburst), .s_axi_gmem_arcache(arcache),
        .s_axi_gmem_arvalid(arvalid), .s_axi_gmem_arready(arready),
        .s_axi_gmem_rdata(rdata), .s_axi_gmem_rresp(rresp), .s_axi_gmem_rlast(rlast),
        .s_axi_gmem_rvalid(rvalid), .s_axi_gmem_rready(rready)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } rbeat_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_model [1024];
    rbeat_t      exp_r [$];
    logic [1:0]  exp_b [$];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [1:0]  last_bresp;
    logic [31:0] first_rdata;
    logic [1:0]  first_rresp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit oor(input logic [63:0] a);
        return (a >> 12) != 64'd0;
    endfunction

    function automatic logic [63:0] rand_addr(input int lo_word, input int hi_word);
        return 64'($urandom_range(hi_word, lo_word)) * 64'd4 + 64'($urandom_range(3, 0));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, awready, 0);
        chk({tag, "_wready"}, wready, 0);
        chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_bresp"}, bresp, 0);
        chk({tag, "_arready"}, arready, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_rresp"}, rresp, 0);
        chk({tag, "_rlast"}, rlast, 0);
    endtask

    // Every cycle: whatever the DUT presents on R or B must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected rvalid=1 with no beat outstanding");
                end else begin
                    chk("rdata", rdata, exp_r[0].d);
                    chk("rresp", rresp, exp_r[0].r);
                    chk("rlast", rlast, exp_r[0].l);
                    if (rready) void'(exp_r.pop_front());
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected bvalid=1 with no response outstanding");
                end else begin
                    chk("bresp", bresp, exp_b[0]);
                    if (bready) void'(exp_b.pop_front());
                end
            end
        end
    end

    task automatic write_burst(input logic [63:0] addr, input int len, input bit bad_last);
        int          flip;
        int          n;
        bit          err;
        logic [63:0] a;
        flip    = bad_last ? int'($urandom_range(len, 0)) : -1;
        err     = 1'b0;
        awaddr  = addr;
        awlen   = 8'(len);
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("aw_wait", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("aw_wready_t1", wready, 1);
        chk("aw_awready_t1", awready, 0);
        for (int b = 0; b <= len; b++) begin
            if ($urandom_range(3, 0) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            wdata  = wd[b];
            wstrb  = ws[b];
            wlast  = (b == len) ^ (b == flip);
            wvalid = 1'b1;
            @(posedge clk); #1;
            a = addr + 64'(4 * b);
            if (oor(a)) begin
                err = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (ws[b][k]) mem_model[a[11:2]][k*8 +: 8] = wd[b][k*8 +: 8];
            end
            if (wlast != (b == len)) err = 1'b1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        last_bresp = err ? 2'b10 : 2'b00;
        exp_b.push_back(last_bresp);
        chk("w_bvalid_u1", bvalid, 1);
        chk("w_wready_u1", wready, 0);
        repeat ($urandom_range(2, 0)) begin
            bready = 1'b0;
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("b_awready_v1", awready, 1);
        chk("b_bvalid_v1", bvalid, 0);
    endtask

    task automatic read_burst(input logic [63:0] addr, input int len, input int rmode);
        int          n;
        int          got;
        bit          ph;
        bit          hs;
        logic [63:0] a;
        rbeat_t      e;
        araddr  = addr;
        arlen   = 8'(len);
        arvalid = 1'b1;
        for (int b = 0; b <= len; b++) begin
            a   = addr + 64'(4 * b);
            e.d = oor(a) ? 32'd0 : mem_model[a[11:2]];
            e.r = oor(a) ? 2'b10 : 2'b00;
            e.l = (b == len);
            exp_r.push_back(e);
        end
        n = 0;
        while (!arready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ar_wait", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("ar_rvalid_t1", rvalid, 1);
        first_rdata = rdata;
        first_rresp = rresp;
        got = 0;
        n   = 0;
        ph  = 1'b1;
        while (got <= len && n < 400) begin
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = ph;
                default: rready = 1'($urandom_range(1, 0));
            endcase
            ph = ~ph;
            hs = rvalid && rready;
            @(posedge clk); #1;
            if (hs) got++;
            n++;
        end
        rready = 1'b0;
        chk("r_beats", got, len + 1);
        chk("r_rvalid_v1", rvalid, 0);
        chk("r_arready_v1", arready, 1);
        chk("r_queue_drained", exp_r.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          sel, len;
        logic [63:0] wa, ra;
        reset_n = 1'b0;
        awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awcache = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arcache = '0; arvalid = 1'b0;
        rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        reset_n = 1'b1;
        #1;
        chk("awready_before_edge", awready, 0);
        @(posedge clk); #1;
        chk("awready_after_rst", awready, 1);
        chk("arready_after_rst", arready, 1);

        // Preload the whole memory so every later read has a known expectation.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'hF;
            end
            write_burst(64'(k * 1024), 255, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA0 + 32'(i);
            ws[i] = 4'hF;
        end
        write_burst(64'h100, 3, 1'b0);
        chk("wr100_bresp", last_bresp, 2'b00);
        chk("model_word_103", mem_model[67], 32'hA3);
        read_burst(64'h100, 3, 0);
        chk("rd100_first", first_rdata, 32'hA0);

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        write_burst(64'h0, 0, 1'b0);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        write_burst(64'h0, 0, 1'b0);
        chk("model_byte_en", mem_model[0], 32'hDE22BE44);
        read_burst(64'h0, 0, 0);
        chk("rd_byte_en", first_rdata, 32'hDE22BE44);

        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'hF;
        end
        write_burst(64'hFF8, 3, 1'b0);
        chk("range_bresp", last_bresp, 2'b10);
        chk("range_model_1023", mem_model[1023], wd[1]);
        read_burst(64'hFF8, 3, 2);
        read_burst(64'h1000, 0, 0);
        chk("range_rd_data", first_rdata, 32'd0);
        chk("range_rd_resp", first_rresp, 2'b10);

        read_burst(64'h200, 7, 1);

        for (int i = 0; i < 3; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'hF;
        end
        write_burst(64'h300, 2, 1'b1);
        chk("bad_wlast_bresp", last_bresp, 2'b10);

        for (int it = 0; it < 40; it++) begin
            sel = int'($urandom_range(2, 0));
            len = int'($urandom_range(15, 0));
            for (int i = 0; i <= len; i++) begin
                wd[i] = $urandom;
                ws[i] = 4'($urandom);
            end
            case (sel)
                0: begin
                    case ($urandom_range(7, 0))
                        0:       wa = rand_addr(1010, 1023);
                        1:       wa = 64'h1_0000_0000 + rand_addr(0, 1023);
                        default: wa = rand_addr(0, 1023 - len);
                    endcase
                    write_burst(wa, len, $urandom_range(5, 0) == 0);
                end
                1: begin
                    ra = ($urandom_range(5, 0) == 0) ? rand_addr(1010, 1023) : rand_addr(0, 1023 - len);
                    read_burst(ra, len, int'($urandom_range(2, 0)));
                end
                default: begin
                    wa = rand_addr(0, 496);
                    ra = rand_addr(512, 1008);
                    fork
                        write_burst(wa, len, 1'b0);
                        read_burst(ra, int'($urandom_range(15, 0)), int'($urandom_range(2, 0)));
                    join
                end
            endcase
        end

        // Reset in the middle of a 4-beat write after two beats have landed.
        awaddr  = 64'h400;
        awlen   = 8'd3;
        awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) begin
            @(posedge clk); #1;
        end
        chk("mid_aw_wait", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wdata  = $urandom;
            wstrb  = 4'hF;
            wlast  = 1'b0;
            wvalid = 1'b1;
            mem_model[256 + b] = wdata;
            @(posedge clk); #1;
        end
        wvalid  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_awready", awready, 1);
        chk("midrst_arready", arready, 1);
        read_burst(64'h400, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sda_gmem_responder.md
# sda_gmem_responder

AXI4 memory responder sitting on the kernel's `m_axi_gmem` master port: it accepts the kernel action's read and write bursts and serves them from an on-chip, byte-enabled word memory. It is the shared-memory endpoint for simulation and standalone builds of kernel actions, so no DDR/host memory model is needed. The read and write channels are independent, each with one outstanding burst.

## Interface

Parameters:
- `ADDR_WIDTH`, 64, AXI address width.
- `DATA_WIDTH`, 32, AXI data width; a power of two, at least 8.
- `MEM_DEPTH_LOG2`, 10, log2 of the memory depth in `DATA_WIDTH` words.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_axi_gmem_awaddr/awlen/awsize/awburst/awcache/awvalid`  in  ADDR_WIDTH/8/3/2/4/1  write address.
- `s_axi_gmem_awready`  out  1.
- `s_axi_gmem_wdata/wstrb/wlast/wvalid`  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data.
- `s_axi_gmem_wready`  out  1.
- `s_axi_gmem_bresp/bvalid`  out  2/1; `s_axi_gmem_bready`  in  1.
- `s_axi_gmem_araddr/arlen/arsize/arburst/arcache/arvalid`  in  same widths as AW  read address.
- `s_axi_gmem_arready`  out  1.
- `s_axi_gmem_rdata/rresp/rlast/rvalid`  out  DATA_WIDTH/2/1/1; `s_axi_gmem_rready`  in  1.

## Operation

- `LSB = log2(DATA_WIDTH/8)`. Word index = `addr[LSB+MEM_DEPTH_LOG2-1:LSB]`. Address bits below LSB are ignored (the address is aligned down).
- A beat is out of range if any bit at or above `LSB+MEM_DEPTH_LOG2` of its beat address is set.
- All bursts are treated as INCR with full-width beats. `*size`, `*burst` and `*cache` are ignored. Beat address = start + n·(DATA_WIDTH/8), computed at full ADDR_WIDTH with no wrap at 4 KB.
- Write FSM, states W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: `awready=1`. An AW handshake latches the address and `awlen`, clears the beat count and error flag, and moves to W_DATA.
  - W_DATA: `wready=1`. Each W handshake writes the bytes whose `wstrb` bit is set. Out-of-range beats are dropped and set the error flag.
  - A `wlast` that does not match (count==awlen) also sets the error flag.
  - The beat where count==awlen moves to W_RESP, regardless of `wlast`.
  - W_RESP: `bvalid=1`, and `bresp` = 2'b10 (SLVERR) if the error flag is set, else 2'b00. A B handshake returns to W_IDLE.
- Read FSM, states R_IDLE → R_DATA → R_IDLE:
  - R_IDLE: `arready=1`. An AR handshake latches the address and `arlen`, and registers the memory word of beat 0 into `rdata`.
  - R_DATA: `rvalid=1`, and `rlast`=(count==arlen).
  - Each R handshake with count<arlen increments the count and, on the same edge, loads the next beat's word.
  - The handshake with `rlast` returns to R_IDLE.
  - For an out-of-range beat, `rdata`=0 and `rresp`=SLVERR; otherwise `rresp`=OKAY.
- Same-word read and write on the same edge: the read returns the old data.
- Reset (at any time, including mid-burst): both FSMs go to idle. All outputs go to 0, including `awready`/`arready`. Memory contents are not cleared.

## Timing

- Outputs are registered. Reset values: every ready/valid/last/resp/data output is 0.
- `awready` and `arready` rise on the first rising edge after `reset_n` deasserts.
- AW handshake at cycle T: `awready`=0 from T+1 and `wready`=1 from T+1. Data may stream one beat per cycle.
- Last W beat at cycle U: `wready`=0 and `bvalid`=1 from U+1, held until `bready`.
- B handshake at V: `awready`=1 at V+1.
- AR handshake at T: `rvalid`=1 with beat 0 at T+1. Sustained throughput is one beat per cycle while `rready` is high.
- `rdata`, `rresp` and `rlast` are stable while `rvalid` is high and `rready` is low.
- Last R handshake at V: `rvalid`=0 and `arready`=1 at V+1.
- Read and write latencies are unaffected by activity on the other channel.

## Structure

- Shared package `sda_gmem_pkg`: write/read state encodings, `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10, and the `LSB` computation.
- Sub-module `sda_gmem_ram`: one write port with byte enables and one synchronous read port, depth 2^MEM_DEPTH_LOG2, read-before-write. The responder instantiates it once.

## Test plan

- Write burst: awaddr=0x100, awlen=3, four beats 0xA0..0xA3 with wstrb=4'hF, `bready` held high → `bvalid` 1 cycle after the last beat, bresp=OKAY.
- Read back with araddr=0x100, arlen=3 → rdata A0,A1,A2,A3 on consecutive cycles starting T+1, `rlast` only on A3.
- Byte enables: write 0xDEADBEEF to 0x0 with wstrb=4'hF, then 0x11223344 with wstrb=4'b0101 → reading 0x0 returns 0xDE22BE44.
- Range error: awaddr=0xFF8, awlen=3 with MEM_DEPTH_LOG2=10 → the first two beats are written, the last two dropped, bresp=SLVERR. Reading the same burst returns 0 and SLVERR on beats 2–3 and OKAY on beats 0–1.
- Backpressure: `rready` toggling 1010… during an 8-beat read → every beat is delivered exactly once, with data held stable while stalled.
- Reset mid-burst: `reset_n` asserted after beat 1 of a 4-beat write → all outputs 0 immediately. After release, `awready`=1, and a new read shows beats 0–1 updated and the rest unchanged.
